// File: rtl/instr_fetch_issue.sv
// Instruction fetch-and-issue sequencer.
// Walks a PC and reads one word per fetch from instruction memory. It holds the
// word in an instruction register and issues it with its MIPS fields split out.
// The issue side uses a valid/ready handshake.
module instr_fetch_issue #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [31:0]     iss_instr,
  output logic [5:0]      iss_opcode,
  output logic [4:0]      iss_rs,
  output logic [4:0]      iss_rt,
  output logic [4:0]      iss_rd,
  output logic [4:0]      iss_shamt,
  output logic [5:0]      iss_funct,
  output logic [15:0]     iss_imm,
  output logic [PC_W-1:0] iss_pc,
  output logic            iss_illegal,
  output logic            busy,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // This is the last wait-count value before the timeout fires.
  // The counter holds the number of WAIT cycles already spent without data.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [PC_W-1:0] iss_pc_q;
  logic [7:0]      wait_cnt_q;
  logic            halt_pend_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (imem_valid)                   state_d = S_ISSUE;
        else if (wait_cnt_q == WAIT_LAST) state_d = S_HALT;
      end
      S_ISSUE: begin
        if (iss_ready) state_d = (halt_pend_q || halt_req) ? S_IDLE : S_REQ;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore handshake/status outputs decoded from the state register
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    iss_valid = 1'b0;
    busy      = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        busy      = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      S_ISSUE: begin
        iss_valid = 1'b1;
        busy      = 1'b1;
      end
      S_HALT:  fault = 1'b1;
      default: ;
    endcase
  end

  // Datapath: PC, instruction register, issue PC, wait counter and halt request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      iss_pc_q    <= '0;
      wait_cnt_q  <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: wait_cnt_q <= '0;
        S_WAIT: begin
          if (imem_valid) begin
            ir_q     <= imem_rdata;
            iss_pc_q <= pc_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_ISSUE: if (iss_ready) pc_q <= pc_q + PC_W'(4);
        default: ;
      endcase
      // Leaving ISSUE for IDLE consumes the halt. Otherwise a halt request is
      // remembered until the next instruction boundary.
      if (state_q == S_ISSUE && state_d == S_IDLE) halt_pend_q <= 1'b0;
      else if (halt_req && state_q != S_HALT)     halt_pend_q <= 1'b1;
    end
  end

  assign iss_instr   = ir_q;
  assign iss_opcode  = ir_q[31:26];
  assign iss_rs      = ir_q[25:21];
  assign iss_rt      = ir_q[20:16];
  assign iss_rd      = ir_q[15:11];
  assign iss_shamt   = ir_q[10:6];
  assign iss_funct   = ir_q[5:0];
  assign iss_imm     = ir_q[15:0];
  assign iss_pc      = iss_pc_q;
  // Only R-type (000000) and ADDI (001000) are supported by the decoder
  assign iss_illegal = !((ir_q[31:26] == 6'b000000) || (ir_q[31:26] == 6'b001000));

endmodule

// File: doc/instr_fetch_issue.md
# instr_fetch_issue

Instruction fetch-and-issue sequencer that drives the opcode decoder from the producer side. It walks a program counter, requests 32-bit words from instruction memory, holds each word in an instruction register, and issues it with its MIPS fields split out (OpCode, rs, rt, rd, shamt, funct, imm) over a valid/ready handshake to the control unit and register file. It stops on request, flags unsupported opcodes, and faults on a memory timeout.

## Interface
- PC_W, 32, program counter / memory address width (≥3)
- RESET_PC, 0, PC value loaded on reset (word aligned)
- MAX_WAIT, 15, max WAIT cycles without imem_valid before fault (1..255)

- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  begin/resume fetching (sampled in IDLE only)
- halt_req  in  1  stop at next instruction boundary (sticky until IDLE)
- imem_req  out  1  one-cycle read request
- imem_addr  out  PC_W  read address (= pc while imem_req)
- imem_valid  in  1  read data valid
- imem_rdata  in  32  read data
- iss_valid  out  1  issued instruction valid
- iss_ready  in  1  consumer accepts
- iss_instr  out  32  full instruction word
- iss_opcode  out  6  instr[31:26]
- iss_rs / iss_rt / iss_rd  out  5 each  instr[25:21] / [20:16] / [15:11]
- iss_shamt  out  5  instr[10:6]
- iss_funct  out  6  instr[5:0]
- iss_imm  out  16  instr[15:0]
- iss_pc  out  PC_W  address the instruction came from
- iss_illegal  out  1  opcode not 6'b000000 (R-type) and not 6'b001000 (ADDI)
- busy  out  1  state is REQ, WAIT or ISSUE
- fault  out  1  memory timeout; sticky until rst

## Operation
- States: IDLE, REQ, WAIT, ISSUE, HALT. All outputs Moore from registers.
- IDLE: all handshake outputs low. start=1 → REQ.
- REQ: imem_req=1, imem_addr=pc, for exactly one cycle → WAIT; the wait counter clears.
- WAIT: imem_valid=1 → load IR from imem_rdata, latch iss_pc=pc → ISSUE. Otherwise counter+1. After MAX_WAIT consecutive WAIT cycles without valid → HALT.
- ISSUE: iss_valid=1; all iss_* fields come from the IR and stay stable until the handshake. iss_valid & iss_ready → pc ← pc+4 (mod 2^PC_W). Then → IDLE if halt_pending or halt_req, else → REQ.
- halt_pending: set by halt_req in any state except HALT. Cleared on entry to IDLE. halt_req during REQ/WAIT does not abort the outstanding fetch; the fetched word is still issued.
- start from IDLE resumes at the current pc; pc is not reloaded.
- HALT: fault=1, imem_req=0, iss_valid=0. Exit only by rst.
- imem_valid outside WAIT is ignored.
- iss_illegal is combinational on the IR opcode, meaningful only with iss_valid. An illegal opcode still issues normally; no stall.
- start while busy or in HALT: ignored.

## Timing
- Reset (rst high at an edge): state=IDLE, pc=RESET_PC, IR=0, counter=0, halt_pending=0, fault=0. Every output is 0 while in reset and the cycle after.
- start sampled high at edge k → imem_req high during cycle k+1.
- imem_valid is accepted from the first WAIT cycle (the cycle after imem_req). A capture at edge m → iss_valid high during cycle m+1.
- Zero-wait memory with iss_ready tied high → one instruction per 3 cycles (REQ, WAIT, ISSUE).
- iss_ready low holds ISSUE indefinitely; there is no timeout on the issue side.
- rst mid-fetch or mid-issue aborts immediately. The pending instruction is dropped and pc returns to RESET_PC.
- pc wrap: pc = 2^PC_W−4 issues, then the next imem_addr is 0.

## Test plan
- Reset/idle: rst for 2 cycles, start=0 for 10 cycles → all outputs 0, no imem_req.
- Streaming: RESET_PC=0, zero-wait memory returning 0x012A4020 at addr 0 and 0x2128000A at addr 4, iss_ready=1 → imem_addr 0,4,8 on cycles 1,4,7. Issue 0: opcode=0, rs=9, rt=10, rd=8, funct=0x20, illegal=0. Issue 1: opcode=0x08, imm=0x000A, iss_pc=4.
- Backpressure: iss_ready low for 5 cycles during ISSUE → iss_valid and fields stable, no new imem_req until the handshake.
- Illegal opcode: word 0x8C220004 (LW) → iss_illegal=1, issued and accepted, pc advances by 4.
- Halt: halt_req pulsed during WAIT → that word issues, then IDLE with no further imem_req. start → fetch resumes at the next pc.
- Timeout/wrap: MAX_WAIT=3 with no imem_valid → HALT after 3 WAIT cycles, fault=1 until rst. Separately, RESET_PC=2^PC_W−4 → second fetch address is 0.
